// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and hands each word downstream.
// Optional performance counters are enabled with `define YSYX_23060201_IFU_PERF_EN.
module ysyx_23060201_ifu #(
  parameter int unsigned                MEM_ADDR_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH     = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0]  RESET_PC       = MEM_ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     imem_rsp_data,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [DATA_WIDTH-1:0]     inst,
  output logic [MEM_ADDR_WIDTH-1:0] inst_pc,
  input  logic                      redirect_en,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc
`ifdef YSYX_23060201_IFU_PERF_EN
  ,
  output logic [31:0]               perf_fetch_cnt,
  output logic [31:0]               perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

  state_e                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] pc_q;

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == StHold);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      case (state_q)
        StReq: begin
          // Memory only samples the address on handshake, so a redirect may retarget freely.
          if (redirect_en) pc_q <= redirect_pc;
          if (imem_req_ready) state_q <= redirect_en ? StDrop : StWait;
        end
        StWait: begin
          if (redirect_en) begin
            pc_q    <= redirect_pc;
            state_q <= imem_rsp_valid ? StReq : StDrop;
          end else if (imem_rsp_valid) begin
            state_q <= StHold;
            inst    <= imem_rsp_data;
            inst_pc <= pc_q;
          end
        end
        StDrop: begin
          if (redirect_en) pc_q <= redirect_pc;
          if (imem_rsp_valid) state_q <= StReq;
        end
        StHold: begin
          if (inst_ready) begin
            state_q <= StReq;
            pc_q    <= redirect_en ? redirect_pc : pc_q + MEM_ADDR_WIDTH'(4);
          end else if (redirect_en) begin
            state_q <= StReq;
            pc_q    <= redirect_pc;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

`ifdef YSYX_23060201_IFU_PERF_EN
  logic fetch_evt;
  logic flush_evt;

  assign fetch_evt = (state_q == StHold) && inst_ready;
  // Squashes: entering DROP, or dropping a held instruction without consuming it.
  assign flush_evt = ((state_q == StReq)  && imem_req_ready && redirect_en) ||
                     ((state_q == StWait) && redirect_en && !imem_rsp_valid) ||
                     ((state_q == StHold) && redirect_en && !inst_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fetch_evt) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (flush_evt) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Self-checking bench for ysyx_23060201_ifu: directed table, corner sequences and random traffic
// against a delivered-PC-order model. Honors YSYX_23060201_IFU_PERF_EN when defined.
module tb_ysyx_23060201_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        w_rst = 1'b1;
  logic        w_req_valid, w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_inst_valid;
  logic        w_inst_ready = 1'b1;
  logic [31:0] w_inst, w_inst_pc;

`ifdef YSYX_23060201_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, w_perf_fetch, w_perf_flush;
`endif

  always #5 clk = ~clk;

  ysyx_23060201_ifu u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc)
`ifdef YSYX_23060201_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  ysyx_23060201_ifu #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .inst_valid     (w_inst_valid),
    .inst_ready     (w_inst_ready),
    .inst           (w_inst),
    .inst_pc        (w_inst_pc),
    .redirect_en    (1'b0),
    .redirect_pc    (32'h0)
`ifdef YSYX_23060201_IFU_PERF_EN
    ,
    .perf_fetch_cnt (w_perf_fetch),
    .perf_flush_cnt (w_perf_flush)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory and model state
  bit          mem_pending = 0;
  int          mem_cnt     = 0;
  logic [31:0] mem_addr    = '0;
  logic [31:0] exp_pc      = 32'h8000_0000;
  logic [31:0] req_log[$];
  int          deliveries  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs driven at negedge, events for the next posedge folded into the model.
  task automatic step(input bit rdy, input int lat, input bit irdy, input bit redir,
                      input logic [31:0] tgt);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pending    = 0;
      end
    end
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_en    = redir;
    redirect_pc    = tgt;
    if (rst) begin
      imem_rsp_valid = 1'b0;
      mem_pending    = 0;
      exp_pc         = 32'h8000_0000;
    end
    #1;
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        chk("one_outstanding", {31'b0, mem_pending | imem_rsp_valid}, 32'd0);
        mem_pending = 1;
        mem_cnt     = lat;
        mem_addr    = imem_req_addr;
        req_log.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) begin
        chk("deliver_pc", inst_pc, exp_pc);
        chk("deliver_data", inst, mem_word(exp_pc));
        deliveries++;
        exp_pc = redir ? tgt : exp_pc + 32'd4;
      end else if (redir) begin
        exp_pc = tgt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rdy;
    bit          irdy;
    bit          exp_req_valid;
    logic [31:0] exp_addr;
    bit          exp_inst_valid;
    logic [31:0] exp_inst_pc;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        seq[9];
    logic [31:0] held_inst, held_pc;
    int          nreq, cnt14, d0;

    seq[0] = '{1, 1, 1, 32'h8000_0000, 0, 32'h0};
    seq[1] = '{1, 1, 0, 32'h8000_0000, 0, 32'h0};
    seq[2] = '{1, 1, 0, 32'h8000_0000, 1, 32'h8000_0000};
    seq[3] = '{1, 1, 1, 32'h8000_0004, 0, 32'h8000_0000};
    seq[4] = '{1, 1, 0, 32'h8000_0004, 0, 32'h8000_0000};
    seq[5] = '{1, 1, 0, 32'h8000_0004, 1, 32'h8000_0004};
    seq[6] = '{1, 1, 1, 32'h8000_0008, 0, 32'h8000_0004};
    seq[7] = '{1, 1, 0, 32'h8000_0008, 0, 32'h8000_0004};
    seq[8] = '{1, 1, 0, 32'h8000_0008, 1, 32'h8000_0008};

    rst = 1'b1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    rst = 1'b0;
    chk("reset_inst", inst, 32'h0);
`ifdef YSYX_23060201_IFU_PERF_EN
    chk("reset_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("reset_perf_flush", perf_flush_cnt, 32'h0);
`endif

    // Sequential fetch, one instruction every third cycle
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("seq%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, seq[i].exp_req_valid});
      chk($sformatf("seq%0d_addr", i), imem_req_addr, seq[i].exp_addr);
      chk($sformatf("seq%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, seq[i].exp_inst_valid});
      chk($sformatf("seq%0d_inst_pc", i), inst_pc, seq[i].exp_inst_pc);
      step(seq[i].rdy, 1, seq[i].irdy, 0, 0);
    end

    // Back-pressure in HOLD
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("bp_inst_pc", inst_pc, 32'h8000_000C);
    held_inst = inst;
    held_pc   = inst_pc;
    nreq      = req_log.size();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_inst", inst, held_inst);
      chk("bp_pc", inst_pc, held_pc);
      chk("bp_no_req", {31'b0, imem_req_valid}, 32'd0);
      step(1, 1, 0, 0, 0);
    end
    chk("bp_req_count", req_log.size(), nreq);
    step(1, 1, 1, 0, 0);
    chk("bp_next_addr", imem_req_addr, held_pc + 32'd4);

    // Branch consumed at handshake
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("br_inst_pc", inst_pc, 32'h8000_0010);
    step(1, 1, 1, 1, 32'h8000_0100);
    chk("br_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("br_addr", imem_req_addr, 32'h8000_0100);

    // Redirect while waiting on a slow response
    step(1, 4, 1, 0, 0);
    step(1, 4, 1, 1, 32'h8000_0200);
    for (int i = 0; i < 3; i++) begin
      chk("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("drop_no_inst", {31'b0, inst_valid}, 32'd0);
      step(1, 4, 1, 0, 0);
    end
    chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("drop_addr", imem_req_addr, 32'h8000_0200);

    // Redirect while the request is not accepted
    step(0, 1, 1, 1, 32'h8000_0300);
    chk("req_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("req_redir_addr", imem_req_addr, 32'h8000_0300);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("req_redir_hs_addr", req_log[req_log.size()-1], 32'h8000_0300);
    step(1, 1, 1, 0, 0);
    chk("req_redir_inst_pc", inst_pc, 32'h8000_0300);
    chk("req_redir_inst", inst, mem_word(32'h8000_0300));
    step(1, 1, 1, 0, 0);

    cnt14 = 0;
    foreach (req_log[i]) if (req_log[i] == 32'h8000_0014) cnt14++;
    chk("br_no_fallthrough_fetch", cnt14, 32'd0);

    // Random traffic against the delivered-order model
    d0 = deliveries;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(1, 4), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC);
    end
    step(1, 1, 1, 0, 0);
    chk("random_progress", {31'b0, (deliveries - d0) >= 20}, 32'd1);

    // Wrap-around and reset mid-fetch on the second instance
    @(negedge clk);
    w_rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    w_rst = 1'b0;
    chk("wrap_req_valid0", {31'b0, w_req_valid}, 32'd1);
    chk("wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
    chk("wrap_inst_valid0", {31'b0, w_inst_valid}, 32'd0);
`ifdef YSYX_23060201_IFU_PERF_EN
    chk("wrap_perf_fetch", w_perf_fetch, 32'h0);
    chk("wrap_perf_flush", w_perf_flush, 32'h0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    w_rsp_valid = 1'b1;
    w_rsp_data  = mem_word(32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_inst_valid1", {31'b0, w_inst_valid}, 32'd1);
    chk("wrap_inst_pc1", w_inst_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    w_rsp_valid = 1'b0;
    @(posedge clk); #1;
    chk("wrap_req_valid2", {31'b0, w_req_valid}, 32'd1);
    chk("wrap_addr2", w_req_addr, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("wrap_wait_no_req", {31'b0, w_req_valid}, 32'd0);
    @(negedge clk);
    w_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_req_valid", {31'b0, w_req_valid}, 32'd1);
    chk("rst_mid_addr", w_req_addr, 32'hFFFF_FFFC);
    chk("rst_mid_inst_valid", {31'b0, w_inst_valid}, 32'd0);
    chk("rst_mid_inst_pc", w_inst_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
